// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: per-button FSM state
// encoding and default timing constants for the 27 MHz board clock.
package btn_defs;

   localparam int DEBOUNCE_CYCLES_27M = 270_000;     // 10 ms
   localparam int LONG_CYCLES_27M     = 27_000_000;  // 1 s

   typedef enum logic [2:0] {
      ST_RELEASED  = 3'd0,
      ST_PRESS_CHK = 3'd1,
      ST_HELD      = 3'd2,
      ST_LONG      = 3'd3,
      ST_REL_CHK   = 3'd4
   } btn_state_e;

   // The debounced level stays high while a release is still being confirmed.
   function automatic logic state_is_down(input btn_state_e s);
      return (s == ST_HELD) || (s == ST_LONG) || (s == ST_REL_CHK);
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle: raw pins in, debounced level and event pulses out.
interface btn_conditioner_if #(
   parameter int NUM_BTN = 2
);
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_long;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_long
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_long
   );
endinterface

// File: rtl/btn_conditioner_debounce_fsm.sv
// One button: two-flop synchroniser, debounce/hold FSM with its counters,
// and registered level / press / release / long-press outputs.
module btn_debounce_fsm
   import btn_defs::*;
#(
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27M,
   parameter int LONG_CYCLES     = LONG_CYCLES_27M
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(LONG_CYCLES - 1);
   localparam logic          IDLE_PIN = ACTIVE_LOW;

   logic           sync1_q, sync1_d;
   logic           sync2_q, sync2_d;
   btn_state_e     state_q, state_d;
   logic [DW-1:0]  dcnt_q, dcnt_d;
   logic [HW-1:0]  hcnt_q, hcnt_d;
   logic           long_flag_q, long_flag_d;
   logic           level_q, level_d;
   logic           press_q, press_d;
   logic           release_q, release_d;
   logic           long_q, long_d;
   logic           pressed;

   assign pressed = sync2_q ^ ACTIVE_LOW;

   always_comb begin
      sync1_d     = raw;
      sync2_d     = sync1_q;
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_flag_d = long_flag_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      case (state_q)
         ST_RELEASED: begin
            if (pressed) begin
               state_d = ST_PRESS_CHK;
               dcnt_d  = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (!pressed) begin
               state_d = ST_RELEASED;
            end else if (dcnt_q == D_LAST) begin
               state_d = ST_HELD;
               hcnt_d  = '0;
               press_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!pressed) begin
               state_d = ST_REL_CHK;
               dcnt_d  = '0;
            end else if (hcnt_q == H_LAST) begin
               state_d     = ST_LONG;
               long_d      = 1'b1;
               long_flag_d = 1'b1;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_LONG: begin
            if (!pressed) begin
               state_d = ST_REL_CHK;
               dcnt_d  = '0;
            end
         end
         ST_REL_CHK: begin
            // A release bounce resumes where it left off; hcnt was frozen.
            if (pressed) begin
               state_d = long_flag_q ? ST_LONG : ST_HELD;
            end else if (dcnt_q == D_LAST) begin
               state_d     = ST_RELEASED;
               release_d   = 1'b1;
               long_flag_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: state_d = ST_RELEASED;
      endcase

      level_d = state_is_down(state_d);
   end

   // NOTE: synchroniser flops reset to the idle pin level so leaving reset
   // never looks like an edge; all state updates use non-blocking assignment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= IDLE_PIN;
         sync2_q     <= IDLE_PIN;
         state_q     <= ST_RELEASED;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         long_flag_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         long_flag_q <= long_flag_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: NUM_BTN fully independent debounce channels
// feeding the verifier control logic.
module btn_conditioner
   import btn_defs::*;
#(
   parameter int NUM_BTN         = 2,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27M,
   parameter int LONG_CYCLES     = LONG_CYCLES_27M
) (
   input logic               clk,
   input logic               rst,
   btn_conditioner_if.slave  bus
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce_fsm #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_fsm (
         .clk       (clk),
         .rst       (rst),
         .raw       (bus.btn_raw[i]),
         .level_o   (bus.btn_level[i]),
         .press_o   (bus.btn_press[i]),
         .release_o (bus.btn_release[i]),
         .long_o    (bus.btn_long[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios with literal
// expectations plus randomized pins compared every cycle to a run-length model.
module tb_btn_conditioner;

   localparam int N = 2;
   localparam int D = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   btn_conditioner_if #(.NUM_BTN(N)) bus ();

   btn_conditioner #(
      .NUM_BTN         (N),
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the pin passes two delay stages; a new level is adopted
   // once D+1 consecutive samples disagree with it, and the long event fires
   // on the L-th consecutive agreeing "down" sample after acceptance.
   logic [N-1:0] m_s1 = '1, m_s2 = '1;
   int           m_run  [N] = '{default: 0};
   int           m_hold [N] = '{default: 0};
   bit           m_lvl  [N] = '{default: 0};
   bit           m_fired[N] = '{default: 0};
   logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;

   task automatic m_reset();
      m_s1 = '1;
      m_s2 = '1;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0; m_hold[i] = 0; m_lvl[i] = 0; m_fired[i] = 0;
      end
      e_level = '0; e_press = '0; e_release = '0; e_long = '0;
   endtask

   task automatic m_step(input logic [N-1:0] raw);
      logic [N-1:0] samp;
      samp = ~m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      e_press = '0; e_release = '0; e_long = '0;
      for (int i = 0; i < N; i++) begin
         if (samp[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == D + 1) begin
               m_lvl[i] = samp[i];
               m_run[i] = 0;
               if (samp[i]) begin
                  e_press[i] = 1'b1;
                  m_hold[i]  = 0;
               end else begin
                  e_release[i] = 1'b1;
                  m_fired[i]   = 0;
               end
            end
         end else begin
            if (m_lvl[i] && m_run[i] == 0 && !m_fired[i]) begin
               m_hold[i]++;
               if (m_hold[i] == L) begin
                  e_long[i]  = 1'b1;
                  m_fired[i] = 1;
               end
            end
            m_run[i] = 0;
         end
         e_level[i] = m_lvl[i];
      end
   endtask

   always @(posedge clk) begin
      if (rst) m_reset();
      else     m_step(bus.btn_raw);
   end

   always @(negedge clk) begin
      check("model_level",   bus.btn_level,   e_level);
      check("model_press",   bus.btn_press,   e_press);
      check("model_release", bus.btn_release, e_release);
      check("model_long",    bus.btn_long,    e_long);
   end

   // Caller sits at a negedge; returns at the negedge after the n-th posedge.
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] all_outs();
      return {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   div;

      rst = 1'b1;
      bus.btn_raw = 2'b11;
      repeat (3) @(negedge clk);
      check("reset_idle_outputs", all_outs(), 8'h00);
      bus.btn_raw = 2'b00;
      repeat (4) @(negedge clk);
      check("reset_pressed_outputs", all_outs(), 8'h00);
      bus.btn_raw = 2'b11;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Clean press and release on button 0.
      bus.btn_raw = 2'b10;
      wait_edges(6);
      check("press_before_edge7", bus.btn_press, 2'b00);
      wait_edges(1);
      check("press_edge7", bus.btn_press, 2'b01);
      check("level_edge7", bus.btn_level, 2'b01);
      wait_edges(1);
      check("press_one_cycle", bus.btn_press, 2'b00);
      check("level_holds", bus.btn_level, 2'b01);
      bus.btn_raw = 2'b11;
      wait_edges(7);
      check("release_edge7", bus.btn_release, 2'b01);
      check("level_fall_edge7", bus.btn_level, 2'b00);
      wait_edges(3);

      // Bounce: two-cycle pulses never satisfy the debounce window.
      acc = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bus.btn_raw = {1'b1, ((c / 2) % 2) == 1};
         @(negedge clk);
         acc |= bus.btn_level[0] | bus.btn_press[0] | bus.btn_release[0] | bus.btn_long[0];
      end
      bus.btn_raw = 2'b11;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc |= bus.btn_level[0] | bus.btn_press[0] | bus.btn_release[0] | bus.btn_long[0];
      end
      check("bounce_no_activity", acc, 1'b0);

      // Long press on button 1, held 30 cycles.
      bus.btn_raw = 2'b01;
      wait_edges(7);
      check("long_btn1_press", bus.btn_press, 2'b10);
      check("long_btn1_level", bus.btn_level, 2'b10);
      wait_edges(9);
      check("long_btn1_not_yet", bus.btn_long, 2'b00);
      wait_edges(1);
      check("long_btn1_pulse", bus.btn_long, 2'b10);
      wait_edges(13);
      check("long_btn1_single", bus.btn_long, 2'b00);
      bus.btn_raw = 2'b11;
      wait_edges(7);
      check("long_btn1_release", bus.btn_release, 2'b10);
      check("long_btn1_level_fall", bus.btn_level, 2'b00);
      wait_edges(3);

      // Release glitch while in the long-held state on button 0.
      bus.btn_raw = 2'b10;
      wait_edges(17);
      check("glitch_long_pulse", bus.btn_long, 2'b01);
      acc = 1'b0;
      bus.btn_raw = 2'b11;
      repeat (2) begin
         @(negedge clk);
         acc |= bus.btn_release[0] | bus.btn_long[0];
      end
      bus.btn_raw = 2'b10;
      repeat (15) begin
         @(negedge clk);
         acc |= bus.btn_release[0] | bus.btn_long[0];
      end
      check("glitch_no_pulse", acc, 1'b0);
      check("glitch_level_held", bus.btn_level[0], 1'b1);

      // Asynchronous reset mid-hold, pin kept pressed.
      #2 rst = 1'b1;
      #1 check("async_reset_level", bus.btn_level, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      acc = 1'b0;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         acc |= bus.btn_release[0] | bus.btn_press[0];
      end
      check("post_reset_quiet", acc, 1'b0);
      wait_edges(1);
      check("post_reset_press", bus.btn_press, 2'b01);
      check("post_reset_level", bus.btn_level, 2'b01);
      bus.btn_raw = 2'b11;
      wait_edges(10);

      // Randomized segments with slow, medium and fast pin activity.
      for (int seg = 0; seg < 30; seg++) begin
         case ($urandom_range(0, 2))
            0:       div = 2;
            1:       div = 8;
            default: div = 64;
         endcase
         for (int c = 0; c < 100; c++) begin
            for (int b = 0; b < N; b++)
               if ($urandom_range(0, div - 1) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
            if ($urandom_range(0, 499) == 0) begin
               #2 rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
            end else begin
               @(negedge clk);
            end
         end
      end

      bus.btn_raw = 2'b11;
      wait_edges(20);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
